pattern_sequencer: RTL and testbench
====================================

# pattern_sequencer

Sequences a serial pattern detector through a latched test pattern, one bit per step, and counts how often the detector flags a match. Sits between the board's switch/button inputs and the detector FSM. It owns the detector's `w` input, its step enable and its synchronous clear, and returns a per-run match count for the LEDs.

## Interface
- `WIDTH`, default 8: pattern length in bits; minimum 2.
- `TICK_DIV`, default 4: `clk` cycles per detector step; minimum 1.
- `clk`, input, 1: single system clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low; when low, all state is forced to reset values immediately.
- `start`, input, 1: level request to run the pattern.
- `pattern`, input, `WIDTH`: test bits, sent MSB first.
- `z_in`, input, 1: detector's Moore output.
- `w`, output, 1: serial bit to the detector.
- `step`, output, 1: one-cycle detector clock enable; the detector samples `w` when `step` is high.
- `det_clr`, output, 1: one-cycle synchronous clear of the detector to its initial state.
- `busy`, output, 1: high in CLEAR and RUN.
- `done`, output, 1: high in DONE.
- `match_count`, output, `$clog2(WIDTH+1)`: result of the last completed run.

## Operation
- Reset values: FSM in IDLE; `w`, `step`, `det_clr`, `busy`, `done` and `match_count` are all 0; internal counters and shift register are 0.
- **IDLE:** `w` = 0. When `start` = 1 at a clock edge, latch `pattern` into the shift register, clear the bit counter, match accumulator and prescaler, then go to CLEAR.
- **CLEAR** (1 cycle): `det_clr` = 1, then go to RUN.
- **RUN:**
  - `w` = shift register MSB.
  - The prescaler counts 0..`TICK_DIV`-1 and wraps. When it equals `TICK_DIV`-1, `step` = 1, the shift register shifts left with 0 fill, and the bit counter increments.
  - In the cycle after each `step`, `z_in` is sampled. If it is 1, the accumulator increments.
  - After the `WIDTH`th step and its sample cycle, copy the accumulator into `match_count` and go to DONE.
- **DONE:** hold `match_count`. Go to IDLE on the first edge where `start` = 0. If `start` stays high, remain in DONE; there is no auto-retrigger.
- `start` and `pattern` are ignored in CLEAR and RUN. The pattern is latched only on the IDLE exit.
- Accumulator maximum is `WIDTH`, so the counter width cannot overflow and no saturation logic is needed.
- `reset` low in any state aborts the run asynchronously. `match_count` returns to 0.

## Timing
- Cycle 0 is the edge at which `start` = 1 is seen in IDLE.
- Cycle 1: CLEAR. From cycle 2: RUN.
- Step k (k = 0..`WIDTH`-1) is at cycle 1+(k+1)·`TICK_DIV`.
- `z_in` for step k is sampled at that cycle +1. With `TICK_DIV` = 1, the sample overlaps the next step (pipelined).
- DONE, with `match_count` valid, is entered at cycle 3+`WIDTH`·`TICK_DIV`.
- `done` drops one cycle after the edge where `start` = 0.

## Configuration
- `SEQ_LOOP_EN`
  - **Defined:** adds input `loop` (1 bit).
    - At run completion with `loop` = 1: `match_count` updates, `done` pulses for exactly one cycle, `pattern` is re-latched, and the FSM goes directly to CLEAR.
    - At run completion with `loop` = 0: behaves as below.
  - **Undefined:** no `loop` port; completion always enters DONE.

## Structure
- Package `seq_pkg`:
  - State codes: IDLE = 2'b00, CLEAR = 2'b01, RUN = 2'b10, DONE = 2'b11.
  - Function for the count width `$clog2(WIDTH+1)`.
- Sub-module `tick_gen`: the `TICK_DIV` prescaler, with synchronous clear and enable and a single-cycle `tick` output. The FSM, shift register and counters stay in `pattern_sequencer`.

## Test plan
In all scenarios the bench's detector model drives `z_in` = 1 in the cycle after any `step` with `w` = 1.
- **Basic run:** `WIDTH`=8, `TICK_DIV`=4, `pattern`=8'hA5, `start` pulse → `det_clr` at cycle 1; `step` at cycles 5,9,…,33 with `w` = 1,0,1,0,0,1,0,1; `done` at cycle 35; `match_count` = 4.
- **No-stall pipelining:** `TICK_DIV`=1, `pattern`=8'hFF → `step` high on cycles 2–9 continuously; `match_count` = 8; `done` at cycle 11.
- **Reset mid-run:** `reset` low at cycle 20 of the basic run → all outputs 0 immediately, FSM in IDLE; a new `start` then runs normally and ends with `match_count` = 4.
- **Ignored inputs:** change `pattern` to 8'h00 and toggle `start` during RUN → result is unchanged at 4. Hold `start` high after DONE → remains in DONE. Drop `start` → IDLE next cycle.
- **All-zero pattern:** `pattern`=8'h00 → `w` never 1; `match_count` = 0; `done` at cycle 35.
- **Loop mode** (`SEQ_LOOP_EN` defined, `loop`=1): first run 8'hA5 → `done` is a one-cycle pulse at cycle 35, `match_count` = 4, CLEAR at cycle 36. Present `pattern`=8'h0F at completion → second run gives `match_count` = 4. Set `loop`=0 → the second run ends in a held DONE.

Source files
------------

// File: rtl/pattern_sequencer_pkg.sv
// seq_pkg: shared state encoding and count-width helper for pattern_sequencer
package seq_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if: board/detector-side bundle of pattern_sequencer
// master (board + detector): start, pattern, z_in (and loop with SEQ_LOOP_EN) out; status in
// slave (sequencer): w, step, det_clr, busy, done, match_count out
interface pattern_sequencer_if #(parameter int WIDTH = 8);
  import seq_pkg::*;
  logic start;
  logic [WIDTH-1:0] pattern;
  logic z_in;
`ifdef SEQ_LOOP_EN
  logic loop;
`endif
  logic w;
  logic step;
  logic det_clr;
  logic busy;
  logic done;
  logic [cnt_w(WIDTH)-1:0] match_count;
  modport master (
    output start, pattern, z_in,
`ifdef SEQ_LOOP_EN
    output loop,
`endif
    input w, step, det_clr, busy, done, match_count
  );
  modport slave (
    input start, pattern, z_in,
`ifdef SEQ_LOOP_EN
    input loop,
`endif
    output w, step, det_clr, busy, done, match_count
  );
endinterface

// File: rtl/pattern_sequencer_tick_gen.sv
// tick_gen: TICK_DIV prescaler with sync clear/enable; tick is high on the last count while enabled
// ports: clk, reset (async active-low), clr, en, tick
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] cnt;
  logic last;
  assign last = cnt == PW'(TICK_DIV - 1);
  assign tick = en & last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + PW'(1);
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: shifts a latched pattern MSB-first into a detector and counts its matches
// ports: clk, reset (async active-low), bus (pattern_sequencer_if.slave)
// optional SEQ_LOOP_EN: adds bus.loop; completion with loop=1 pulses done and restarts with a fresh pattern
module pattern_sequencer
  import seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4
) (
  input logic clk,
  input logic reset,
  pattern_sequencer_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] bit_cnt, acc, mc;
  logic step_d, tick, step, latch, fin;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .clr(latch),
    .en(state == RUN),
    .tick(tick)
  );
  // gate off the prescaler once all bits are sent so TICK_DIV=1 does not overrun
  assign step = tick & (bit_cnt != CW'(WIDTH));
  assign bus.step = step;
  assign bus.w = (state == RUN) & sr[WIDTH-1];
  assign bus.det_clr = state == CLEAR;
  assign bus.busy = (state == CLEAR) | (state == RUN);
  assign bus.done = state == DONE;
  assign bus.match_count = mc;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    latch = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        nxt = CLEAR;
        latch = 1'b1;
      end
      CLEAR: nxt = RUN;
      RUN: if (step_d && bit_cnt == CW'(WIDTH)) begin
        nxt = DONE;
        fin = 1'b1;
      end
      DONE: begin
`ifdef SEQ_LOOP_EN
        if (bus.loop) begin
          nxt = CLEAR;
          latch = 1'b1;
        end else
`endif
        if (!bus.start) nxt = IDLE;
      end
    endcase
  end
  // z_in answers the step of the previous cycle; the last answer is folded straight into the result
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sr <= '0;
      bit_cnt <= '0;
      acc <= '0;
      step_d <= 1'b0;
      mc <= '0;
    end else begin
      step_d <= step;
      if (latch) begin
        sr <= bus.pattern;
        bit_cnt <= '0;
      end else if (step) begin
        sr <= {sr[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (latch) acc <= '0;
      else if (step_d && bus.z_in) acc <= acc + CW'(1);
      if (fin) mc <= acc + CW'(bus.z_in);
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed self-checking bench for pattern_sequencer (TICK_DIV 4 and 1)
module tb_pattern_sequencer;
  import seq_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int pass_n = 0;
  int fail_n = 0;
  int c = 0;
  always #5 clk = ~clk;
  pattern_sequencer_if #(.WIDTH(8)) a ();
  pattern_sequencer_if #(.WIDTH(8)) b ();
  pattern_sequencer #(.WIDTH(8), .TICK_DIV(4)) dut_a (.clk(clk), .reset(reset), .bus(a));
  pattern_sequencer #(.WIDTH(8), .TICK_DIV(1)) dut_b (.clk(clk), .reset(reset), .bus(b));
  // detector model: reports a match in the cycle after any step carrying w=1
  always @(posedge clk or negedge reset)
    if (!reset) begin
      a.z_in <= 1'b0;
      b.z_in <= 1'b0;
    end else begin
      a.z_in <= a.step & a.w;
      b.z_in <= b.step & b.w;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s c=%0d obs=%0h exp=%0h", tag, c, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
    c++;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, a.busy, 0);
    chk({tag, "_done"}, a.done, 0);
    chk({tag, "_step"}, a.step, 0);
    chk({tag, "_clr"}, a.det_clr, 0);
    chk({tag, "_w"}, a.w, 0);
    chk({tag, "_cnt"}, a.match_count, 0);
  endtask
  task automatic run_a(input logic [7:0] pat, input int exp_cnt, input int abort_at,
                       input bit disturb, input bit hold);
    logic [7:0] p;
    p = pat;
    a.pattern = pat;
    a.start = 1'b1;
    c = 0;
    nxt();
    a.start = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        chk_zero("abort");
        reset = 1'b1;
        return;
      end
      chk("det_clr", a.det_clr, 32'(i == 1));
      chk("step", a.step, 32'(i >= 5 && i <= 33 && (i - 1) % 4 == 0));
      if (i >= 2 && i <= 33) chk("w", a.w, p[7 - (i - 2) / 4]);
      if (i == 34) chk("w_drained", a.w, 0);
      chk("busy", a.busy, 32'(i <= 34));
      chk("done", a.done, 32'(i == 35));
      if (disturb && i == 10) a.pattern = 8'h00;
      if (disturb && i >= 12 && i <= 15) a.start = ~a.start;
      if (hold && i == 30) a.start = 1'b1;
      if (i < 35) nxt();
    end
    chk("count", a.match_count, exp_cnt);
    if (hold) begin
      nxt();
      chk("hold_done1", a.done, 1);
      nxt();
      chk("hold_done2", a.done, 1);
      a.start = 1'b0;
    end
    nxt();
    chk("idle_done", a.done, 0);
    chk("idle_busy", a.busy, 0);
    chk("held_count", a.match_count, exp_cnt);
  endtask
  initial begin
    a.start = 1'b0;
    a.pattern = '0;
    b.start = 1'b0;
    b.pattern = '0;
`ifdef SEQ_LOOP_EN
    a.loop = 1'b0;
    b.loop = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    nxt();
    run_a(8'hA5, 4, 0, 1'b0, 1'b0);
    run_a(8'hA5, 4, 20, 1'b0, 1'b0);
    run_a(8'hA5, 4, 0, 1'b0, 1'b0);
    run_a(8'hA5, 4, 0, 1'b1, 1'b1);
    run_a(8'h00, 0, 0, 1'b0, 1'b0);
    b.pattern = 8'hFF;
    b.start = 1'b1;
    c = 0;
    nxt();
    b.start = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      chk("b_det_clr", b.det_clr, 32'(i == 1));
      chk("b_step", b.step, 32'(i >= 2 && i <= 9));
      chk("b_done", b.done, 32'(i == 11));
      if (i < 11) nxt();
    end
    chk("b_count", b.match_count, 8);
`ifdef SEQ_LOOP_EN
    a.loop = 1'b1;
    a.pattern = 8'hA5;
    a.start = 1'b1;
    c = 0;
    nxt();
    a.start = 1'b0;
    while (c < 34) nxt();
    a.pattern = 8'h0F;
    nxt();
    chk("loop_done", a.done, 1);
    chk("loop_count1", a.match_count, 4);
    nxt();
    chk("loop_pulse_end", a.done, 0);
    chk("loop_clear", a.det_clr, 1);
    a.loop = 1'b0;
    a.start = 1'b1;
    while (c < 70) nxt();
    chk("loop_done2", a.done, 1);
    chk("loop_count2", a.match_count, 4);
    nxt();
    chk("loop_held", a.done, 1);
    a.start = 1'b0;
    nxt();
    chk("loop_idle", a.done, 0);
`endif
    $display("%0d/%0d checks passed", pass_n, pass_n + fail_n);
    $finish;
  end
endmodule
